// File: rtl/multicycle_control.sv
// multicycle_control: sequencing FSM plus opcode/funct decode for a multicycle
// RV32I datapath. It drives all datapath selects and enables, including the
// immediate-format select for the extend unit.
//
// Optional feature: define MULTICYCLE_MEM_WAIT_EN to make FETCH, MEM_READ and
// MEM_WRITE hold until i_mem_ready. Without it i_mem_ready is ignored and
// every memory state lasts one cycle.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_FETCH     | read instruction at PC, load IR/old PC, PC <= PC + 4
// S_DECODE    | ALUOut <= old PC + imm (branch/JAL target), dispatch on op
// S_MEM_ADR   | ALUOut <= rs1 + imm (load/store address)
// S_MEM_READ  | read data memory at ALUOut
// S_MEM_WB    | write loaded data to rd, retire
// S_MEM_WRITE | write rs2 to memory at ALUOut, retire
// S_EXEC_R    | ALUOut <= rs1 op rs2
// S_EXEC_I    | ALUOut <= rs1 op imm
// S_EXEC_U    | ALUOut <= imm (LUI) or old PC + imm (AUIPC)
// S_ALU_WB    | write ALUOut to rd, retire
// S_JALR      | ALUOut <= rs1 + imm (jump target)
// S_JAL_LINK  | PC <= ALUOut, ALU computes link old PC + 4
// S_BRANCH    | compare rs1/rs2, PC <= ALUOut when taken, retire
// S_ILLEGAL   | flag undecodable instruction, no writes

module multicycle_control (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_write,
    output logic       o_adr_src,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic       o_reg_write,
    output logic [1:0] o_result_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [2:0] o_imm_src,
    output logic [3:0] o_alu_control,
    output logic       o_instr_retire,
    output logic       o_illegal_instr
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_U,
        S_ALU_WB,
        S_JALR,
        S_JAL_LINK,
        S_BRANCH,
        S_ILLEGAL
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_ready;
    logic [3:0] w_alu_dec;
    logic [3:0] w_alu_br;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign w_ready = i_mem_ready;
`else
    // Memory always completes in one cycle; the handshake input is parked.
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = i_mem_ready;
    assign w_ready            = 1'b1;
`endif

    // State register; reset restarts the sequence at FETCH.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:     w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_op)
                    OP_LOAD, OP_STORE: w_next = S_MEM_ADR;
                    OP_R:              w_next = S_EXEC_R;
                    OP_IMM:            w_next = S_EXEC_I;
                    OP_BRANCH:         w_next = (i_funct3[2:1] == 2'b01) ? S_ILLEGAL : S_BRANCH;
                    OP_JAL:            w_next = S_JAL_LINK;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI, OP_AUIPC:  w_next = S_EXEC_U;
                    OP_FENCE:          w_next = S_FETCH;
                    default:           w_next = S_ILLEGAL;
                endcase
            end
            S_MEM_ADR:   w_next = i_op[5] ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_next = w_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    w_next = S_FETCH;
            S_MEM_WRITE: w_next = w_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R:    w_next = S_ALU_WB;
            S_EXEC_I:    w_next = S_ALU_WB;
            S_EXEC_U:    w_next = S_ALU_WB;
            S_ALU_WB:    w_next = S_FETCH;
            S_JALR:      w_next = S_JAL_LINK;
            S_JAL_LINK:  w_next = S_ALU_WB;
            S_BRANCH:    w_next = S_FETCH;
            S_ILLEGAL:   w_next = S_FETCH;
            default:     w_next = S_FETCH;
        endcase
    end

    // R/I-type ALU decode; SUB exists only for R-type, I-type ADDI ignores bit 30.
    always_comb begin
        w_alu_dec = ALU_ADD;
        case (i_funct3)
            3'b000:  w_alu_dec = ((r_state == S_EXEC_R) && i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  w_alu_dec = ALU_SLL;
            3'b010:  w_alu_dec = ALU_SLT;
            3'b011:  w_alu_dec = ALU_SLTU;
            3'b100:  w_alu_dec = ALU_XOR;
            3'b101:  w_alu_dec = i_funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  w_alu_dec = ALU_OR;
            3'b111:  w_alu_dec = ALU_AND;
            default: w_alu_dec = ALU_ADD;
        endcase
    end

    // Branch compare op: equality via SUB/zero, ordered compares via SLT/SLTU.
    always_comb begin
        w_alu_br = ALU_SUB;
        case (i_funct3[2:1])
            2'b00:   w_alu_br = ALU_SUB;
            2'b10:   w_alu_br = ALU_SLT;
            2'b11:   w_alu_br = ALU_SLTU;
            default: w_alu_br = ALU_ADD;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        o_imm_src = 3'b000;
        case (i_op)
            OP_LOAD, OP_IMM, OP_JALR: o_imm_src = 3'b000;
            OP_STORE:                 o_imm_src = 3'b010;
            OP_BRANCH:                o_imm_src = 3'b001;
            OP_LUI, OP_AUIPC:         o_imm_src = 3'b011;
            OP_JAL:                   o_imm_src = 3'b100;
            default:                  o_imm_src = 3'b000;
        endcase
    end

    // Per-state datapath controls; reset suppresses every side effect.
    always_comb begin
        o_mem_req       = 1'b0;
        o_mem_write     = 1'b0;
        o_adr_src       = 1'b0;
        o_ir_write      = 1'b0;
        o_pc_write      = 1'b0;
        o_reg_write     = 1'b0;
        o_result_src    = 2'b00;
        o_alu_src_a     = 2'b00;
        o_alu_src_b     = 2'b00;
        o_alu_control   = ALU_ADD;
        o_instr_retire  = 1'b0;
        o_illegal_instr = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_mem_req    = 1'b1;
                o_ir_write   = w_ready;
                o_pc_write   = w_ready;
                o_alu_src_a  = 2'b00;
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
            end
            S_DECODE: begin
                o_alu_src_a    = 2'b01;
                o_alu_src_b    = 2'b01;
                o_instr_retire = (i_op == OP_FENCE);
            end
            S_MEM_ADR, S_JALR: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
            end
            S_MEM_READ: begin
                o_mem_req = 1'b1;
                o_adr_src = 1'b1;
            end
            S_MEM_WB: begin
                o_result_src   = 2'b01;
                o_reg_write    = 1'b1;
                o_instr_retire = 1'b1;
            end
            S_MEM_WRITE: begin
                o_mem_req      = 1'b1;
                o_adr_src      = 1'b1;
                o_mem_write    = w_ready;
                o_instr_retire = w_ready;
            end
            S_EXEC_R: begin
                o_alu_src_a   = 2'b10;
                o_alu_src_b   = 2'b00;
                o_alu_control = w_alu_dec;
            end
            S_EXEC_I: begin
                o_alu_src_a   = 2'b10;
                o_alu_src_b   = 2'b01;
                o_alu_control = w_alu_dec;
            end
            S_EXEC_U: begin
                o_alu_src_a = i_op[5] ? 2'b11 : 2'b01;
                o_alu_src_b = 2'b01;
            end
            S_ALU_WB: begin
                o_result_src   = 2'b00;
                o_reg_write    = 1'b1;
                o_instr_retire = 1'b1;
            end
            S_JAL_LINK: begin
                o_alu_src_a  = 2'b01;
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b00;
                o_pc_write   = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a    = 2'b10;
                o_alu_src_b    = 2'b00;
                o_result_src   = 2'b00;
                o_alu_control  = w_alu_br;
                // bne/bge/bgeu branch on the inverted compare result
                o_pc_write     = i_zero ^ (i_funct3[2] ^ i_funct3[0]);
                o_instr_retire = 1'b1;
            end
            S_ILLEGAL: begin
                o_illegal_instr = 1'b1;
            end
            default: begin
                o_mem_req = 1'b0;
            end
        endcase
        if (i_reset) begin
            o_mem_req       = 1'b0;
            o_mem_write     = 1'b0;
            o_ir_write      = 1'b0;
            o_pc_write      = 1'b0;
            o_reg_write     = 1'b0;
            o_instr_retire  = 1'b0;
            o_illegal_instr = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each instruction pushes its
// expected per-cycle control vector, and the vector is popped and compared
// against the DUT outputs on every falling edge.
module tb_multicycle_control;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] imm_src;
        logic [3:0] alu;
        logic       retire;
        logic       illegal;
    } ctl_t;

    typedef enum {K_R, K_I, K_LUI, K_AUIPC, K_LOAD, K_STORE, K_BR, K_JAL,
                  K_JALR, K_FENCE, K_ILL} kind_t;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [6:0] i_op = 7'b0;
    logic [2:0] i_funct3 = 3'b0;
    logic       i_funct7b5 = 1'b0;
    logic       i_zero = 1'b0;
    logic       i_mem_ready = 1'b1;
    logic       o_mem_req, o_mem_write, o_adr_src, o_ir_write, o_pc_write, o_reg_write;
    logic [1:0] o_result_src, o_alu_src_a, o_alu_src_b;
    logic [2:0] o_imm_src;
    logic [3:0] o_alu_control;
    logic       o_instr_retire, o_illegal_instr;

    ctl_t  w_obs;
    ctl_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fails  = 0;

    multicycle_control u_dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_op           (i_op),
        .i_funct3       (i_funct3),
        .i_funct7b5     (i_funct7b5),
        .i_zero         (i_zero),
        .i_mem_ready    (i_mem_ready),
        .o_mem_req      (o_mem_req),
        .o_mem_write    (o_mem_write),
        .o_adr_src      (o_adr_src),
        .o_ir_write     (o_ir_write),
        .o_pc_write     (o_pc_write),
        .o_reg_write    (o_reg_write),
        .o_result_src   (o_result_src),
        .o_alu_src_a    (o_alu_src_a),
        .o_alu_src_b    (o_alu_src_b),
        .o_imm_src      (o_imm_src),
        .o_alu_control  (o_alu_control),
        .o_instr_retire (o_instr_retire),
        .o_illegal_instr(o_illegal_instr)
    );

    always #5 i_clk = ~i_clk;

    assign w_obs = {o_mem_req, o_mem_write, o_adr_src, o_ir_write, o_pc_write, o_reg_write,
                    o_result_src, o_alu_src_a, o_alu_src_b, o_imm_src, o_alu_control,
                    o_instr_retire, o_illegal_instr};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] en_bits(input ctl_t c);
        return {c.mem_req, c.mem_write, c.ir_write, c.pc_write, c.reg_write, c.retire, c.illegal};
    endfunction

    function automatic ctl_t base(input logic [2:0] imm);
        ctl_t c = '0;
        c.imm_src = imm;
        return c;
    endfunction

    task automatic push(input string tag, input ctl_t c);
        exp_q.push_back(c);
        tag_q.push_back(tag);
    endtask

    function automatic logic dflt_ready();
`ifdef MULTICYCLE_MEM_WAIT_EN
        return 1'b1;
`else
        return 1'($urandom_range(0, 1));
`endif
    endfunction

    task automatic step(input logic rdy);
        ctl_t  e;
        string t;
        i_mem_ready = rdy;
        @(negedge i_clk);
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq(t, 32'(w_obs), 32'(e));
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain();
        while (exp_q.size() != 0) step(dflt_ready());
    endtask

    task automatic reset_cycle(input string tag, input logic rdy);
        i_reset     = 1'b1;
        i_mem_ready = rdy;
        @(negedge i_clk);
        check_eq(tag, 32'(en_bits(w_obs)), 32'd0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_fetch(input string n, input logic [2:0] imm, input logic full);
        ctl_t c = base(imm);
        c.mem_req    = 1'b1;
        c.ir_write   = full;
        c.pc_write   = full;
        c.src_b      = 2'b10;
        c.result_src = 2'b10;
        push({n, "/fetch"}, c);
    endtask

    task automatic push_wb(input string n, input logic [2:0] imm);
        ctl_t c = base(imm);
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
        push({n, "/alu_wb"}, c);
    endtask

    task automatic push_link(input string n, input logic [2:0] imm);
        ctl_t c = base(imm);
        c.src_a    = 2'b01;
        c.src_b    = 2'b10;
        c.pc_write = 1'b1;
        push({n, "/jal_link"}, c);
    endtask

    // Pushes the expected sequence for one instruction starting at FETCH.
    task automatic push_instr(input string n, input kind_t k, input logic [2:0] imm,
                              input logic [3:0] alu, input logic pcw);
        ctl_t c;
        push_fetch(n, imm, 1'b1);
        c = base(imm);
        c.src_a  = 2'b01;
        c.src_b  = 2'b01;
        c.retire = (k == K_FENCE);
        push({n, "/decode"}, c);
        case (k)
            K_R, K_I: begin
                c = base(imm); c.src_a = 2'b10; c.src_b = (k == K_I) ? 2'b01 : 2'b00; c.alu = alu;
                push({n, "/exec"}, c);
                push_wb(n, imm);
            end
            K_LUI, K_AUIPC: begin
                c = base(imm); c.src_a = (k == K_LUI) ? 2'b11 : 2'b01; c.src_b = 2'b01;
                push({n, "/exec_u"}, c);
                push_wb(n, imm);
            end
            K_LOAD, K_STORE: begin
                c = base(imm); c.src_a = 2'b10; c.src_b = 2'b01;
                push({n, "/mem_adr"}, c);
                c = base(imm); c.mem_req = 1'b1; c.adr_src = 1'b1;
                if (k == K_STORE) begin
                    c.mem_write = 1'b1; c.retire = 1'b1;
                    push({n, "/mem_write"}, c);
                end else begin
                    push({n, "/mem_read"}, c);
                    c = base(imm); c.result_src = 2'b01; c.reg_write = 1'b1; c.retire = 1'b1;
                    push({n, "/mem_wb"}, c);
                end
            end
            K_BR: begin
                c = base(imm); c.src_a = 2'b10; c.alu = alu; c.pc_write = pcw; c.retire = 1'b1;
                push({n, "/branch"}, c);
            end
            K_JAL: begin
                push_link(n, imm);
                push_wb(n, imm);
            end
            K_JALR: begin
                c = base(imm); c.src_a = 2'b10; c.src_b = 2'b01;
                push({n, "/jalr"}, c);
                push_link(n, imm);
                push_wb(n, imm);
            end
            K_ILL: begin
                c = base(imm); c.illegal = 1'b1;
                push({n, "/illegal"}, c);
            end
            default: begin
            end
        endcase
    endtask

    task automatic run(input string n, input kind_t k, input logic [6:0] op,
                       input logic [2:0] f3, input logic f7, input logic z,
                       input logic [2:0] imm, input logic [3:0] alu, input logic pcw);
        i_op       = op;
        i_funct3   = f3;
        i_funct7b5 = f7;
        i_zero     = z;
        push_instr(n, k, imm, alu, pcw);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_t c;
        #1;
        reset_cycle("reset_c1", 1'b1);
        reset_cycle("reset_c2", 1'b0);
        i_reset = 1'b0;

        //   name      kind     op          f3      f7    zero  imm     alu      pcw
        run("sub",    K_R,     7'b0110011, 3'b000, 1'b1, 1'b0, 3'b000, 4'b0001, 1'b0);
        run("add",    K_R,     7'b0110011, 3'b000, 1'b0, 1'b1, 3'b000, 4'b0000, 1'b0);
        run("addi7",  K_I,     7'b0010011, 3'b000, 1'b1, 1'b0, 3'b000, 4'b0000, 1'b0);
        run("srai",   K_I,     7'b0010011, 3'b101, 1'b1, 1'b0, 3'b000, 4'b1001, 1'b0);
        run("srl",    K_R,     7'b0110011, 3'b101, 1'b0, 1'b0, 3'b000, 4'b1000, 1'b0);
        run("and",    K_R,     7'b0110011, 3'b111, 1'b0, 1'b0, 3'b000, 4'b0010, 1'b0);
        run("or",     K_R,     7'b0110011, 3'b110, 1'b0, 1'b0, 3'b000, 4'b0011, 1'b0);
        run("xor",    K_R,     7'b0110011, 3'b100, 1'b0, 1'b0, 3'b000, 4'b0100, 1'b0);
        run("slt",    K_R,     7'b0110011, 3'b010, 1'b0, 1'b0, 3'b000, 4'b0101, 1'b0);
        run("sltiu",  K_I,     7'b0010011, 3'b011, 1'b0, 1'b0, 3'b000, 4'b0110, 1'b0);
        run("slli",   K_I,     7'b0010011, 3'b001, 1'b0, 1'b0, 3'b000, 4'b0111, 1'b0);
        run("lw",     K_LOAD,  7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b0);
        run("sw",     K_STORE, 7'b0100011, 3'b010, 1'b0, 1'b0, 3'b010, 4'b0000, 1'b0);
        run("bge_t",  K_BR,    7'b1100011, 3'b101, 1'b0, 1'b1, 3'b001, 4'b0101, 1'b1);
        run("bge_nt", K_BR,    7'b1100011, 3'b101, 1'b0, 1'b0, 3'b001, 4'b0101, 1'b0);
        run("beq_t",  K_BR,    7'b1100011, 3'b000, 1'b0, 1'b1, 3'b001, 4'b0001, 1'b1);
        run("bne_t",  K_BR,    7'b1100011, 3'b001, 1'b0, 1'b0, 3'b001, 4'b0001, 1'b1);
        run("blt_t",  K_BR,    7'b1100011, 3'b100, 1'b0, 1'b0, 3'b001, 4'b0101, 1'b1);
        run("bltu_n", K_BR,    7'b1100011, 3'b110, 1'b0, 1'b1, 3'b001, 4'b0110, 1'b0);
        run("br_f3_2",K_ILL,   7'b1100011, 3'b010, 1'b0, 1'b0, 3'b001, 4'b0000, 1'b0);
        run("jal",    K_JAL,   7'b1101111, 3'b000, 1'b0, 1'b0, 3'b100, 4'b0000, 1'b0);
        run("jalr",   K_JALR,  7'b1100111, 3'b000, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b0);
        run("lui",    K_LUI,   7'b0110111, 3'b000, 1'b0, 1'b0, 3'b011, 4'b0000, 1'b0);
        run("auipc",  K_AUIPC, 7'b0010111, 3'b000, 1'b0, 1'b0, 3'b011, 4'b0000, 1'b0);
        run("fence",  K_FENCE, 7'b0001111, 3'b000, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b0);
        run("op0",    K_ILL,   7'b0000000, 3'b000, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b0);

`ifdef MULTICYCLE_MEM_WAIT_EN
        // FETCH stalled three cycles, then the R-type completes normally.
        i_op = 7'b0110011; i_funct3 = 3'b000; i_funct7b5 = 1'b1;
        for (int i = 0; i < 3; i++) push_fetch("fetch_wait", 3'b000, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0);
        push_instr("sub_after_wait", K_R, 3'b000, 4'b0001, 1'b0);
        drain();
`endif

        // Reset while the store sits in MEM_WRITE must suppress the write.
        i_op = 7'b0100011; i_funct3 = 3'b010; i_funct7b5 = 1'b0;
        push_fetch("sw_abort", 3'b010, 1'b1);
        c = base(3'b010); c.src_a = 2'b01; c.src_b = 2'b01;
        push("sw_abort/decode", c);
        c = base(3'b010); c.src_a = 2'b10; c.src_b = 2'b01;
        push("sw_abort/mem_adr", c);
        drain();
`ifdef MULTICYCLE_MEM_WAIT_EN
        c = base(3'b010); c.mem_req = 1'b1; c.adr_src = 1'b1;
        push("sw_abort/mem_write_wait", c);
        step(1'b0);
`endif
        reset_cycle("reset_in_mem_write", 1'b0);
        i_reset = 1'b0;
        run("add_after_rst", K_R, 7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
